// File: rtl/FreeListTypes.sv
// Shared types and default sizing for the physical register free list.
package FreeListTypes;

  localparam int unsigned FL_DEFAULT_ENTRY_NUM      = 64;
  localparam int unsigned FL_DEFAULT_ENTRY_BIT_SIZE = 7;
  localparam int unsigned FL_DEFAULT_PUSH_WIDTH     = 2;
  localparam int unsigned FL_DEFAULT_POP_WIDTH      = 2;
  localparam int unsigned FL_INDEX_BITS             = $clog2(FL_DEFAULT_ENTRY_NUM);

  typedef logic [FL_INDEX_BITS-1:0] FreeListIndexPath;
  typedef logic [FL_INDEX_BITS:0]   FreeListCountPath;

  typedef enum logic {
    FL_PHASE_INIT = 1'b0,
    FL_PHASE_RUN  = 1'b1
  } FreeListPhase;

endpackage

// File: rtl/free_list_lane_compact.sv
// Prefix popcount of a lane request vector: per-lane compacted write offset
// and total number of active lanes. Purely combinational.
module free_list_lane_compact #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned COUNT_BITS = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]                 req,
  output logic [WIDTH-1:0][COUNT_BITS-1:0] offset,
  output logic [COUNT_BITS-1:0]            total
);

  logic [COUNT_BITS-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int k = 0; k < WIDTH; k++) begin
      offset[k] = acc;
      acc       = acc + COUNT_BITS'(req[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/phy_reg_free_list.sv
// Multi-port circular free list of physical register numbers.
// Optional duplicate/range push checking under RSD_FREE_LIST_DUP_CHECK_EN.
module phy_reg_free_list
  import FreeListTypes::*;
#(
  parameter int unsigned ENTRY_NUM      = FL_DEFAULT_ENTRY_NUM,
  parameter int unsigned ENTRY_BIT_SIZE = FL_DEFAULT_ENTRY_BIT_SIZE,
  parameter int unsigned PUSH_WIDTH     = FL_DEFAULT_PUSH_WIDTH,
  parameter int unsigned POP_WIDTH      = FL_DEFAULT_POP_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     ready,
  input  logic [PUSH_WIDTH-1:0]                    pushReq,
  input  logic [PUSH_WIDTH-1:0][ENTRY_BIT_SIZE-1:0] pushData,
  input  logic [POP_WIDTH-1:0]                     popReq,
  output logic [POP_WIDTH-1:0][ENTRY_BIT_SIZE-1:0] popData,
  output logic [$clog2(ENTRY_NUM):0]               count,
  output logic                                     canAllocate,
  output logic                                     error
);

  localparam int unsigned INDEX_BITS    = $clog2(ENTRY_NUM);
  localparam int unsigned COUNT_BITS    = INDEX_BITS + 1;
  localparam int unsigned SUM_BITS      = COUNT_BITS + 1;
  localparam int unsigned PUSH_CNT_BITS = $clog2(PUSH_WIDTH + 1);
  localparam int unsigned POP_CNT_BITS  = $clog2(POP_WIDTH + 1);

  FreeListPhase phase, phaseNext;

  logic [ENTRY_BIT_SIZE-1:0] ram [ENTRY_NUM];
  logic [INDEX_BITS-1:0]     head, tail, initPtr;

  logic [PUSH_WIDTH-1:0][PUSH_CNT_BITS-1:0] pushOffset;
  logic [PUSH_CNT_BITS-1:0]                 nPush;
  logic [POP_CNT_BITS-1:0]                  nPop;
  logic [COUNT_BITS-1:0]                    countAfterPop;
  logic initDone, underflow, overflow, popAccept, pushAccept, dupErr;

  free_list_lane_compact #(
    .WIDTH      (PUSH_WIDTH),
    .COUNT_BITS (PUSH_CNT_BITS)
  ) pushCompact (
    .req    (pushReq),
    .offset (pushOffset),
    .total  (nPush)
  );

  always_comb begin
    nPop = '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      nPop = nPop + POP_CNT_BITS'(popReq[i]);
    end
  end

  // Pop is judged against current occupancy; push against occupancy after the accepted pop.
  always_comb begin
    initDone      = (COUNT_BITS'(initPtr) + COUNT_BITS'(PUSH_WIDTH)) == COUNT_BITS'(ENTRY_NUM);
    underflow     = (phase == FL_PHASE_RUN) && (COUNT_BITS'(nPop) > count);
    popAccept     = (phase == FL_PHASE_RUN) && !underflow;
    countAfterPop = popAccept ? (count - COUNT_BITS'(nPop)) : count;
    overflow      = (phase == FL_PHASE_RUN) &&
                    ((SUM_BITS'(countAfterPop) + SUM_BITS'(nPush)) > SUM_BITS'(ENTRY_NUM));
    pushAccept    = (phase == FL_PHASE_RUN) && !overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= FL_PHASE_INIT;
    end else begin
      phase <= phaseNext;
    end
  end

  always_comb begin
    phaseNext = phase;
    if ((phase == FL_PHASE_INIT) && initDone) begin
      phaseNext = FL_PHASE_RUN;
    end
  end

  always_comb begin
    ready       = 1'b0;
    canAllocate = 1'b0;
    popData     = '0;
    if (phase == FL_PHASE_RUN) begin
      ready       = 1'b1;
      canAllocate = (count >= COUNT_BITS'(POP_WIDTH));
      for (int i = 0; i < POP_WIDTH; i++) begin
        popData[i] = ram[head + INDEX_BITS'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      initPtr <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      error   <= 1'b0;
    end else if (phase == FL_PHASE_INIT) begin
      initPtr <= initPtr + INDEX_BITS'(PUSH_WIDTH);
      count   <= count + COUNT_BITS'(PUSH_WIDTH);
    end else begin
      if (popAccept) begin
        head <= head + INDEX_BITS'(nPop);
      end
      if (pushAccept) begin
        tail <= tail + INDEX_BITS'(nPush);
      end
      count <= countAfterPop + (pushAccept ? COUNT_BITS'(nPush) : COUNT_BITS'(0));
      error <= error | underflow | overflow | dupErr;
    end
  end

  // Storage: init fill, then compacted pushes at tail; held off during rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (phase == FL_PHASE_INIT) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
          ram[initPtr + INDEX_BITS'(k)] <= ENTRY_BIT_SIZE'(initPtr) + ENTRY_BIT_SIZE'(k);
        end
      end else if (pushAccept) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
          if (pushReq[k]) begin
            ram[tail + INDEX_BITS'(pushOffset[k])] <= pushData[k];
          end
        end
      end
    end
  end

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
  logic [ENTRY_NUM-1:0] occupied, occupiedNext;

  // Pops clear before pushes set, so a register freed and re-pushed in one cycle is legal.
  always_comb begin
    occupiedNext = occupied;
    dupErr       = 1'b0;
    if (phase == FL_PHASE_INIT) begin
      for (int k = 0; k < PUSH_WIDTH; k++) begin
        occupiedNext[initPtr + INDEX_BITS'(k)] = 1'b1;
      end
    end else begin
      if (popAccept) begin
        for (int i = 0; i < POP_WIDTH; i++) begin
          if (POP_CNT_BITS'(i) < nPop) begin
            occupiedNext[ram[head + INDEX_BITS'(i)][INDEX_BITS-1:0]] = 1'b0;
          end
        end
      end
      if (pushAccept) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
          if (pushReq[k]) begin
            if ((pushData[k] >= ENTRY_BIT_SIZE'(ENTRY_NUM)) ||
                occupiedNext[pushData[k][INDEX_BITS-1:0]]) begin
              dupErr = 1'b1;
            end
            occupiedNext[pushData[k][INDEX_BITS-1:0]] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= '0;
    end else begin
      occupied <= occupiedNext;
    end
  end
`else
  assign dupErr = 1'b0;
`endif

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Randomized self-checking bench for phy_reg_free_list using a queue-based
// model of the free list. Duplicate checks enabled with RSD_FREE_LIST_DUP_CHECK_EN.
module tb_phy_reg_free_list;

  localparam int unsigned EN = 64;
  localparam int unsigned EB = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready, canAllocate, error;
  logic [1:0] pushReq = '0;
  logic [1:0][EB-1:0] pushData = '0;
  logic [1:0] popReq = '0;
  logic [1:0][EB-1:0] popData;
  logic [6:0] count;

  int checks = 0;
  int errors = 0;
  int freeQ[$];
  int pool[$];
  bit mErr = 1'b0;
  bit mRun = 1'b0;

  always #5 clk = ~clk;

  phy_reg_free_list dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .pushReq    (pushReq),
    .pushData   (pushData),
    .popReq     (popReq),
    .popData    (popData),
    .count      (count),
    .canAllocate(canAllocate),
    .error      (error)
  );

  function automatic bit model_has(int v);
    foreach (freeQ[j]) if ((freeQ[j] % EN) == (v % EN)) return 1'b1;
    return 1'b0;
  endfunction

  // Free list as a FIFO of register numbers; pop first, then push.
  task automatic model_apply();
    int nPop, nPush, v;
    if (!mRun) return;
    nPop = $countones(popReq);
    if (nPop > freeQ.size()) mErr = 1'b1;
    else repeat (nPop) pool.push_back(freeQ.pop_front());
    nPush = $countones(pushReq);
    if (freeQ.size() + nPush > EN) mErr = 1'b1;
    else begin
      for (int k = 0; k < 2; k++) begin
        if (pushReq[k]) begin
          v = int'(pushData[k]);
`ifdef RSD_FREE_LIST_DUP_CHECK_EN
          if (v >= EN || model_has(v)) mErr = 1'b1;
`endif
          freeQ.push_back(v);
          for (int j = 0; j < pool.size(); j++) begin
            if (pool[j] == v) begin
              pool.delete(j);
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] pr, input int d0, input int d1, input logic [1:0] qr);
    pushReq     = pr;
    pushData[0] = EB'(d0);
    pushData[1] = EB'(d1);
    popReq      = qr;
    #1;
  endtask

  task automatic clk_step();
    model_apply();
    @(posedge clk);
    #1;
    pushReq  = '0;
    pushData = '0;
    popReq   = '0;
  endtask

  task automatic do_reset(input logic [1:0] pr, input logic [1:0] qr);
    int n;
    mRun = 1'b0;
    rst = 1'b1;
    pushReq = pr;
    pushData[0] = EB'(11);
    pushData[1] = EB'(12);
    popReq = qr;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushReq = '0;
    popReq = '0;
    checks++;
    if (ready !== 1'b0 || count !== 7'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%0b count=%0d error=%0b exp 0/0/0", ready, count, error);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready ready=%0b exp 1 after %0d cycles", ready, n);
    end
    freeQ.delete();
    pool.delete();
    for (int i = 0; i < EN; i++) freeQ.push_back(i);
    mErr = 1'b0;
    mRun = 1'b1;
    checks++;
    if (count !== 7'(EN)) begin
      errors++;
      $display("FAIL init_count got %0d exp %0d", count, EN);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mRun = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", ready); end
    checks++;
    if (count !== 7'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %0b exp 0", error); end
    checks++;
    if (canAllocate !== 1'b0) begin errors++; $display("FAIL rst_canalloc got %0b exp 0", canAllocate); end
    checks++;
    if (popData !== '0) begin errors++; $display("FAIL rst_popdata got %0h exp 0", popData); end
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (count !== 7'(2 * i) || ready !== (i == 32)) begin
        errors++;
        $display("FAIL init_progress cycle %0d count=%0d ready=%0b exp %0d/%0b", i, count, ready, 2 * i, i == 32);
      end
    end
    for (int i = 0; i < EN; i++) freeQ.push_back(i);
    mRun = 1'b1;
    checks++;
    if (canAllocate !== 1'b1) begin errors++; $display("FAIL init_canalloc got %0b exp 1", canAllocate); end
    checks++;
    if (popData[0] !== EB'(freeQ[0]) || popData[1] !== EB'(freeQ[1])) begin
      errors++;
      $display("FAIL init_popdata got %0d,%0d exp %0d,%0d", popData[0], popData[1], freeQ[0], freeQ[1]);
    end
  endtask

  task automatic test_pop_seq();
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 0, 0, 2'b11);
      checks++;
      if (popData[0] !== EB'(2 * c) || popData[1] !== EB'(2 * c + 1)) begin
        errors++;
        $display("FAIL pop_seq %0d got %0d,%0d exp %0d,%0d", c, popData[0], popData[1], 2 * c, 2 * c + 1);
      end
      clk_step();
    end
    checks++;
    if (count !== 7'd58 || count !== 7'(freeQ.size())) begin
      errors++;
      $display("FAIL pop_seq_count got %0d exp 58", count);
    end
  endtask

  task automatic test_wrap_compaction();
    while (freeQ.size() > 0) begin
      drive(2'b00, 0, 0, 2'b11);
      clk_step();
    end
    checks++;
    if (count !== 7'd0 || canAllocate !== 1'b0) begin
      errors++;
      $display("FAIL empty count=%0d canAlloc=%0b exp 0/0", count, canAllocate);
    end
    drive(2'b10, 0, 9, 2'b00);
    clk_step();
    drive(2'b11, 17, 3, 2'b00);
    clk_step();
    checks++;
    if (count !== 7'd3) begin errors++; $display("FAIL compact_count got %0d exp 3", count); end
    drive(2'b00, 0, 0, 2'b11);
    checks++;
    if (popData[0] !== EB'(9) || popData[1] !== EB'(17)) begin
      errors++;
      $display("FAIL compact_pop01 got %0d,%0d exp 9,17", popData[0], popData[1]);
    end
    clk_step();
    drive(2'b00, 0, 0, 2'b01);
    checks++;
    if (popData[0] !== EB'(3)) begin errors++; $display("FAIL compact_pop2 got %0d exp 3", popData[0]); end
    clk_step();
    checks++;
    if (count !== 7'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL compact_end count=%0d error=%0b exp 0/0", count, error);
    end
  endtask

  task automatic test_simultaneous();
    drive(2'b01, 20, 0, 2'b00);
    clk_step();
    checks++;
    if (count !== 7'd1) begin errors++; $display("FAIL sim_setup count got %0d exp 1", count); end
    drive(2'b11, 40, 41, 2'b01);
    checks++;
    if (popData[0] !== EB'(20)) begin errors++; $display("FAIL sim_pop got %0d exp 20", popData[0]); end
    clk_step();
    checks++;
    if (count !== 7'd2) begin errors++; $display("FAIL sim_count got %0d exp 2", count); end
    checks++;
    if (popData[0] !== EB'(40)) begin errors++; $display("FAIL sim_next got %0d exp 40", popData[0]); end
  endtask

  task automatic test_underflow();
    drive(2'b00, 0, 0, 2'b01);
    clk_step();
    drive(2'b00, 0, 0, 2'b11);
    clk_step();
    checks++;
    if (error !== 1'b1 || error !== mErr) begin errors++; $display("FAIL underflow_error got %0b exp 1", error); end
    checks++;
    if (count !== 7'd1) begin errors++; $display("FAIL underflow_count got %0d exp 1", count); end
    checks++;
    if (popData[0] !== EB'(41)) begin errors++; $display("FAIL underflow_head got %0d exp 41", popData[0]); end
  endtask

  task automatic test_overflow();
    do_reset(2'b00, 2'b00);
    drive(2'b01, 5, 0, 2'b00);
    clk_step();
    checks++;
    if (error !== 1'b1 || error !== mErr) begin errors++; $display("FAIL overflow_error got %0b exp 1", error); end
    checks++;
    if (count !== 7'd64) begin errors++; $display("FAIL overflow_count got %0d exp 64", count); end
  endtask

  task automatic test_random();
    int sz, nPop, room, allow, r0, r1, d0, d1;
    logic [1:0] pm, qm;
    do_reset(2'b00, 2'b00);
    for (int it = 0; it < 400; it++) begin
      sz = freeQ.size();
      nPop = int'($urandom_range(0, 2));
      if (nPop > sz) nPop = sz;
      qm = 2'((1 << nPop) - 1);
      pm = 2'($urandom_range(0, 3));
      room = EN - (sz - nPop);
      allow = (pool.size() < room) ? pool.size() : room;
      if (allow == 0) pm = 2'b00;
      else if (allow == 1 && pm == 2'b11) pm = 2'b01;
      r0 = (pool.size() > 0) ? int'($urandom_range(0, pool.size() - 1)) : 0;
      r1 = (pool.size() > 1) ? (r0 + 1 + int'($urandom_range(0, pool.size() - 2))) % pool.size() : r0;
      d0 = (pool.size() > 0) ? pool[r0] : 0;
      d1 = pm[0] ? ((pool.size() > 1) ? pool[r1] : 0) : d0;
      drive(pm, d0, d1, qm);
      for (int i = 0; i < 2; i++) begin
        if (i < sz) begin
          checks++;
          if (popData[i] !== EB'(freeQ[i])) begin
            errors++;
            $display("FAIL rand_popdata it %0d lane %0d got %0d exp %0d", it, i, popData[i], freeQ[i]);
          end
        end
      end
      clk_step();
      checks++;
      if (count !== 7'(freeQ.size()) || error !== mErr || canAllocate !== (freeQ.size() >= 2)) begin
        errors++;
        $display("FAIL rand_state it %0d count=%0d error=%0b canAlloc=%0b exp %0d/%0b/%0b",
                 it, count, error, canAllocate, freeQ.size(), mErr, freeQ.size() >= 2);
      end
    end
  endtask

  task automatic test_midrun_reset();
    drive(2'b00, 0, 0, 2'b11);
    clk_step();
    do_reset(2'b11, 2'b11);
    for (int c = 0; c < 32; c++) begin
      drive(2'b00, 0, 0, 2'b11);
      checks++;
      if (popData[0] !== EB'(2 * c) || popData[1] !== EB'(2 * c + 1)) begin
        errors++;
        $display("FAIL reinit_pop %0d got %0d,%0d exp %0d,%0d", c, popData[0], popData[1], 2 * c, 2 * c + 1);
      end
      clk_step();
    end
    checks++;
    if (count !== 7'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reinit_end count=%0d error=%0b exp 0/0", count, error);
    end
  endtask

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
  task automatic test_dup_check();
    do_reset(2'b00, 2'b00);
    drive(2'b00, 0, 0, 2'b01);
    clk_step();
    drive(2'b01, 5, 0, 2'b00);
    clk_step();
    checks++;
    if (error !== 1'b1 || error !== mErr) begin errors++; $display("FAIL dup_error got %0b exp 1", error); end
    do_reset(2'b00, 2'b00);
    drive(2'b00, 0, 0, 2'b01);
    clk_step();
    drive(2'b01, 0, 0, 2'b00);
    clk_step();
    checks++;
    if (error !== 1'b0 || count !== 7'd64) begin
      errors++;
      $display("FAIL dup_legal error=%0b count=%0d exp 0/64", error, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pop_seq();
    test_wrap_compaction();
    test_simultaneous();
    test_underflow();
    test_overflow();
    test_random();
    test_midrun_reset();
`ifdef RSD_FREE_LIST_DUP_CHECK_EN
    test_dup_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
